// File: rtl/score_keeper.sv
// score_keeper: turns clean_field line-clear results into score, lines and level, and paces gravity with drop_tick.
// Ports:
//   clk, rst (sync, active-low), restart (sync clear for a new game)
//   clean_done/lines_cleared : line-clear result; one award per rising edge of clean_done
//   pause/soft_drop          : freeze the drop counter / use the fast drop interval
//   score, lines_total, level, level_up, drop_tick : registered outputs
module score_keeper #(
  parameter int SCORE_W         = 20,
  parameter int SCORE_MAX       = 999999,
  parameter int LINES_MAX       = 999,
  parameter int LINES_PER_LEVEL = 10,
  parameter int MAX_LEVEL       = 15,
  parameter int CNT_W           = 25,
  parameter int DROP_BASE       = 25000000,
  parameter int DROP_STEP       = 1500000,
  parameter int DROP_MIN        = 2500000,
  parameter int SOFT_DROP       = 2500000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               restart,
  input  logic               clean_done,
  input  logic [2:0]         lines_cleared,
  input  logic               pause,
  input  logic               soft_drop,
  output logic [SCORE_W-1:0] score,
  output logic [9:0]         lines_total,
  output logic [3:0]         level,
  output logic               level_up,
  output logic               drop_tick
);
  localparam logic [SCORE_W:0] S_MAX  = SCORE_MAX[SCORE_W:0];
  localparam logic [10:0]      L_MAX  = LINES_MAX[10:0];
  localparam logic [4:0]       LPL    = LINES_PER_LEVEL[4:0];
  localparam logic [3:0]       LV_MAX = MAX_LEVEL[3:0];
  localparam logic [CNT_W-1:0] D_BASE = DROP_BASE[CNT_W-1:0];
  localparam logic [CNT_W-1:0] D_STEP = DROP_STEP[CNT_W-1:0];
  localparam logic [CNT_W-1:0] D_MIN  = DROP_MIN[CNT_W-1:0];
  localparam logic [CNT_W-1:0] D_SOFT = SOFT_DROP[CNT_W-1:0];

  logic             done_q;
  logic             s1_v;
  logic [2:0]       s1_n;
  logic [14:0]      s1_pts;
  logic [3:0]       lil;
  logic [CNT_W-1:0] cnt;

  logic             rise;
  logic [2:0]       n_c;
  logic [14:0]      base_c;
  logic [4:0]       lvl1;
  logic [14:0]      pts_c;
  logic [SCORE_W:0] score_sum;
  logic [10:0]      lines_sum;
  logic [4:0]       lil_sum;
  logic             wrap;
  logic             lvl_inc;
  logic [CNT_W-1:0] dec;
  logic [CNT_W-1:0] lvl_iv;
  logic [CNT_W-1:0] interval;
  logic             tick_c;

  // done_q clears on reset, so clean_done already high at release counts as a rise
  assign rise   = clean_done & ~done_q;
  assign n_c    = lines_cleared > 3'd4 ? 3'd4 : lines_cleared;

  always_comb begin
    base_c = n_c == 3'd1 ? 15'd40 :
             n_c == 3'd2 ? 15'd100 :
             n_c == 3'd3 ? 15'd300 :
             n_c == 3'd4 ? 15'd1200 : 15'd0;
    lvl1   = {1'b0, level} + 5'd1;
    pts_c  = base_c * {10'b0, lvl1};
  end

  // commit arithmetic for the award held in stage 1
  always_comb begin
    score_sum = {1'b0, score} + {{(SCORE_W-14){1'b0}}, s1_pts};
    lines_sum = {1'b0, lines_total} + {8'b0, s1_n};
    lil_sum   = {1'b0, lil} + {2'b0, s1_n};
    wrap      = lil_sum >= LPL;
    lvl_inc   = wrap && level < LV_MAX;
  end

  // level-scaled interval, floored at D_MIN and never allowed to underflow
  always_comb begin
    dec      = CNT_W'(level) * D_STEP;
    lvl_iv   = dec >= D_BASE ? '0 : D_BASE - dec;
    interval = soft_drop ? D_SOFT : (lvl_iv < D_MIN ? D_MIN : lvl_iv);
    tick_c   = !pause && cnt >= interval - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst || restart) begin
      done_q      <= 1'b0;
      s1_v        <= 1'b0;
      s1_n        <= '0;
      s1_pts      <= '0;
      lil         <= '0;
      cnt         <= '0;
      score       <= '0;
      lines_total <= '0;
      level       <= '0;
      level_up    <= 1'b0;
      drop_tick   <= 1'b0;
    end else begin
      done_q   <= clean_done;
      s1_v     <= rise;
      s1_n     <= n_c;
      s1_pts   <= pts_c;
      level_up <= s1_v && lvl_inc;
      if (s1_v) begin
        score       <= score_sum > S_MAX ? S_MAX[SCORE_W-1:0] : score_sum[SCORE_W-1:0];
        lines_total <= lines_sum > L_MAX ? L_MAX[9:0] : lines_sum[9:0];
        lil         <= 4'(wrap ? lil_sum - LPL : lil_sum);
        if (lvl_inc) level <= level + 4'd1;
      end
      if (!pause) cnt <= tick_c ? '0 : cnt + CNT_W'(1);
      drop_tick <= tick_c;
    end
  end
endmodule

// File: tb/tb_score_keeper.sv
// tb_score_keeper: scoreboard bench for score_keeper with directed vectors.
module tb_score_keeper;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        restart = 1'b0;
  logic        clean_done = 1'b0;
  logic [2:0]  lines_cleared = 3'd0;
  logic        pause = 1'b0;
  logic        soft_drop = 1'b0;
  logic [19:0] score, sat_score;
  logic [9:0]  lines_total, sat_lines;
  logic [3:0]  level, sat_level;
  logic        level_up, sat_level_up, drop_tick, sat_drop_tick;

  score_keeper #(.DROP_BASE(20), .DROP_STEP(2), .DROP_MIN(4), .SOFT_DROP(3)) dut (
    .clk(clk), .rst(rst), .restart(restart), .clean_done(clean_done),
    .lines_cleared(lines_cleared), .pause(pause), .soft_drop(soft_drop),
    .score(score), .lines_total(lines_total), .level(level),
    .level_up(level_up), .drop_tick(drop_tick)
  );

  score_keeper #(.SCORE_MAX(1000), .DROP_BASE(20), .DROP_STEP(2), .DROP_MIN(4), .SOFT_DROP(3)) u_sat (
    .clk(clk), .rst(rst), .restart(restart), .clean_done(clean_done),
    .lines_cleared(lines_cleared), .pause(pause), .soft_drop(soft_drop),
    .score(sat_score), .lines_total(sat_lines), .level(sat_level),
    .level_up(sat_level_up), .drop_tick(sat_drop_tick)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int c; int sc; int ln; int lv; int lu; int sat;} st_t;
  typedef struct {int c; int tk;} tk_t;
  st_t sq[$];
  tk_t tq[$];
  int tests = 0, fails = 0;

  task automatic chk(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic push_s(int c, int sc, int ln, int lv, int lu, int sat);
    st_t e;
    e.c = c; e.sc = sc; e.ln = ln; e.lv = lv; e.lu = lu; e.sat = sat;
    sq.push_back(e);
  endtask

  task automatic push_t(int c, int tk);
    tk_t e;
    e.c = c; e.tk = tk;
    tq.push_back(e);
  endtask

  task automatic award(logic [2:0] n);
    lines_cleared = n;
    clean_done = 1'b1;
    @(negedge clk);
    clean_done = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_restart();
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
  endtask

  // monitor: compares whatever the scoreboard expects for the current cycle
  st_t ms;
  tk_t mt;
  always @(negedge clk) begin
    while (sq.size() > 0 && sq[0].c <= cyc) begin
      ms = sq.pop_front();
      if (ms.c < cyc) chk("late_state", cyc, ms.c);
      else begin
        chk("score", int'(score), ms.sc);
        chk("lines_total", int'(lines_total), ms.ln);
        chk("level", int'(level), ms.lv);
        chk("level_up", int'(level_up), ms.lu);
        if (ms.sat >= 0) chk("sat_score", int'(sat_score), ms.sat);
      end
    end
    while (tq.size() > 0 && tq[0].c <= cyc) begin
      mt = tq.pop_front();
      if (mt.c < cyc) chk("late_tick", cyc, mt.c);
      else chk("drop_tick", int'(drop_tick), mt.tk);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    int c;
    bit found;
    // reset and default gravity
    repeat (2) @(negedge clk);
    rst = 1'b1;
    c = cyc;
    push_s(c + 1, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 60; k++) push_t(c + k, int'(k % 20 == 0));
    repeat (61) @(negedge clk);
    // single line held high: one award only
    c = cyc;
    lines_cleared = 3'd1;
    clean_done = 1'b1;
    for (int k = 2; k <= 7; k++) push_s(c + k, 40, 1, 0, 0, 40);
    repeat (5) @(negedge clk);
    clean_done = 1'b0;
    repeat (4) @(negedge clk);
    // level up through four 4-line awards spaced 2 cycles
    c = cyc;
    push_s(c + 1, 0, 0, 0, 0, 0);
    do_restart();
    c = cyc;
    push_s(c + 2, 1200, 4, 0, 0, 1000);
    push_s(c + 4, 2400, 8, 0, 0, 1000);
    push_s(c + 6, 3600, 12, 1, 1, 1000);
    push_s(c + 7, 3600, 12, 1, 0, 1000);
    push_s(c + 8, 6000, 16, 1, 0, 1000);
    repeat (4) award(3'd4);
    repeat (3) @(negedge clk);
    // clamping at level 0
    do_restart();
    c = cyc;
    push_s(c + 2, 0, 0, 0, 0, 0);
    award(3'd0);
    c = cyc;
    push_s(c + 2, 1200, 4, 0, 0, 1000);
    award(3'd7);
    repeat (3) @(negedge clk);
    // restart kills an award that is in flight
    c = cyc;
    push_s(c + 2, 0, 0, 0, 0, 0);
    push_s(c + 3, 0, 0, 0, 0, 0);
    lines_cleared = 3'd4;
    clean_done = 1'b1;
    @(negedge clk);
    clean_done = 1'b0;
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    repeat (3) @(negedge clk);
    // soft drop interval of 3
    soft_drop = 1'b1;
    c = cyc;
    for (int k = 1; k <= 12; k++) push_t(c + k, int'(k > 1 && (k - 1) % 3 == 0));
    do_restart();
    repeat (12) @(negedge clk);
    soft_drop = 1'b0;
    // pause freezes the counter for 50 cycles
    c = cyc + 1;
    for (int k = 1; k <= 72; k++) push_t(c + k, int'(k == 70));
    do_restart();
    repeat (5) @(negedge clk);
    pause = 1'b1;
    repeat (50) @(negedge clk);
    pause = 1'b0;
    repeat (20) @(negedge clk);
    // drive to level 8, then interval hits the floor of 4
    do_restart();
    for (int i = 0; i < 19; i++) award(3'd4);
    c = cyc;
    push_s(c + 2, 105600, 80, 8, 1, 1000);
    award(3'd4);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      found = drop_tick;
    end
    chk("tick_at_level8", int'(found), 1);
    c = cyc;
    for (int k = 1; k <= 12; k++) push_t(c + k, int'(k % 4 == 0));
    repeat (14) @(negedge clk);
    chk("state_queue_drained", sq.size(), 0);
    chk("tick_queue_drained", tq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
